// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: default geometry, FSM state encoding and
// the BIP HALT opcode. Optional feature macro used by this block: LOADER_CHECKSUM_EN.
package program_loader_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DEPTH_DEF  = 1024;
  localparam int unsigned LEN_W      = 16;

  // BIP opcode that an empty (all-zero) memory word decodes to.
  localparam logic [4:0] OP_HALT = 5'b00000;

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StDataHi,
    StDataLo,
    StChk,
    StDone,
    StError
  } state_e;

  // Byte stream is accepted in every state except the two terminal ones.
  function automatic logic state_accepts(state_e s);
    return (s != StDone) && (s != StError);
  endfunction

endpackage

// File: rtl/program_loader_word_asm.sv
// Byte pairing for the program loader: holds the high byte of a big-endian pair and presents
// the assembled 16-bit word combinationally with the current (low) byte. When
// LOADER_CHECKSUM_EN is defined it also keeps a running XOR of the payload bytes.
module program_loader_word_asm
  import program_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic [7:0]  i_data,
  input  logic        i_take_hi,
`ifdef LOADER_CHECKSUM_EN
  input  logic        i_acc,
  output logic [7:0]  o_xor,
`endif
  output logic [15:0] o_word
);

  logic [7:0] r_hi;

  // High-byte holding register; cleared on reset and on restart.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_hi <= 8'h00;
    end else if (i_clr) begin
      r_hi <= 8'h00;
    end else if (i_take_hi) begin
      r_hi <= i_data;
    end
  end

  assign o_word = {r_hi, i_data};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_xor;

  // Running XOR over payload bytes only; header bytes never reach i_acc.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_xor <= 8'h00;
    end else if (i_clr) begin
      r_xor <= 8'h00;
    end else if (i_acc) begin
      r_xor <= r_xor ^ i_data;
    end
  end

  assign o_xor = r_xor;
`endif

endmodule

// File: rtl/program_loader.sv
// Program loader: fills BIP instruction memory from a byte stream framed as a big-endian
// 16-bit word count followed by big-endian instruction words, writing addresses 0..N-1 and
// holding the CPU in reset until the image is complete.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (state StChk).
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic              i_start,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_rst_n,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [LEN_W-1:0] DepthLen = LEN_W'(DEPTH);

  state_e             r_state;
  state_e             w_state_d;
  logic               r_in_ready;
  logic               r_done;
  logic               r_error;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic [LEN_W-1:0]   r_count;
  logic [LEN_W-1:0]   r_word_cnt;

  logic               w_hs;
  logic               w_take_hi;
  logic               w_write;
  logic               w_len_load;
  logic               w_clr;
  logic               w_last;
  logic [15:0]        w_word;

  assign w_hs   = i_in_valid && r_in_ready;
  assign w_last = (r_word_cnt + 16'd1) == r_count;

`ifdef LOADER_CHECKSUM_EN
  logic       w_acc;
  logic [7:0] w_xor;

  assign w_acc = w_hs && ((r_state == StDataHi) || (r_state == StDataLo));
`endif

  program_loader_word_asm u_word_asm (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_clr),
    .i_data    (i_in_data),
    .i_take_hi (w_take_hi),
`ifdef LOADER_CHECKSUM_EN
    .i_acc     (w_acc),
    .o_xor     (w_xor),
`endif
    .o_word    (w_word)
  );

  // Next-state decode; every move except restart requires a byte handshake.
  always_comb begin
    w_state_d  = r_state;
    w_take_hi  = 1'b0;
    w_write    = 1'b0;
    w_len_load = 1'b0;
    w_clr      = 1'b0;
    case (r_state)
      StLenHi: begin
        if (w_hs) begin
          w_take_hi = 1'b1;
          w_state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (w_hs) begin
          w_len_load = 1'b1;
          if (w_word == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_d = StChk;
`else
            w_state_d = StDone;
`endif
          end else if (w_word > DepthLen) begin
            w_state_d = StError;
          end else begin
            w_state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        if (w_hs) begin
          w_take_hi = 1'b1;
          w_state_d = StDataLo;
        end
      end
      StDataLo: begin
        if (w_hs) begin
          w_write = 1'b1;
          if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
            w_state_d = StChk;
`else
            w_state_d = StDone;
`endif
          end else begin
            w_state_d = StDataHi;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (w_hs) begin
          w_state_d = (i_in_data == w_xor) ? StDone : StError;
        end
      end
`endif
      StDone, StError: begin
        if (i_start) begin
          w_clr     = 1'b1;
          w_state_d = StLenHi;
        end
      end
      default: w_state_d = StLenHi;
    endcase
  end

  // State, handshake/status flags, word counter and memory write port.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= StLenHi;
      r_in_ready  <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_count     <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= state_accepts(w_state_d);
      // done trails entry into StDone by one cycle so it follows the final write pulse.
      r_done     <= (w_state_d == StDone) && (r_state == StDone);
      r_error    <= (w_state_d == StError);
      r_mem_we   <= w_write;
      if (w_len_load) begin
        r_count <= w_word;
      end
      if (w_write) begin
        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
        r_mem_wdata <= DATA_W'(w_word);
        r_word_cnt  <= r_word_cnt + 16'd1;
      end
      if (w_clr) begin
        r_mem_addr  <= '0;
        r_mem_wdata <= '0;
        r_count     <= '0;
        r_word_cnt  <= '0;
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_cpu_rst_n = r_done;
  assign o_done      = r_done;
  assign o_error     = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader. Inputs change on the falling edge and
// outputs are sampled there too; checksum vectors run when LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        start;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_rst_n;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];

  always #5 clk = ~clk;

  program_loader dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_data   (in_data),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_start     (start),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_cpu_rst_n (cpu_rst_n),
    .o_done      (done),
    .o_error     (error)
  );

  // Log every write strobe seen on the falling edge.
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a byte and return on the falling edge after its handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("ready_timeout", 32'd0, 32'd1);
    else @(negedge clk);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  // Called right after the final handshake: done must rise exactly one cycle later.
  task automatic check_done_seq(input string tag);
    in_valid = 1'b0;
    check_eq({tag, "_done_early"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd1);
    check_eq({tag, "_ready_low"}, {31'd0, in_ready}, 32'd0);
    check_eq({tag, "_we_low"}, {31'd0, mem_we}, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_write(input string tag, input int idx, input logic [10:0] a,
                             input logic [15:0] d);
    if (idx < wr_addr_q.size()) begin
      check_eq({tag, "_addr"}, {21'd0, wr_addr_q[idx]}, {21'd0, a});
      check_eq({tag, "_data"}, {16'd0, wr_data_q[idx]}, {16'd0, d});
    end else begin
      check_eq({tag, "_missing"}, 32'd0, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check_eq({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check_eq({tag, "_addr"}, {21'd0, mem_addr}, 32'd0);
    check_eq({tag, "_wdata"}, {16'd0, mem_wdata}, 32'd0);
    check_eq({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
  endtask

  initial begin
    rst      = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    start    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ready_rise", {31'd0, in_ready}, 32'd1);

    // 1: three words back-to-back.
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h18); send_byte(8'h04);
    send_byte(8'h08); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h15);
`else
    check_eq("t1_last_we", {31'd0, mem_we}, 32'd1);
`endif
    check_done_seq("t1");
    check_eq("t1_nwr", wr_addr_q.size(), 32'd3);
    check_write("t1_w0", 0, 11'd0, 16'h1804);
    check_write("t1_w1", 1, 11'd1, 16'h0801);
    check_write("t1_w2", 2, 11'd2, 16'h0000);

    // 2: empty image.
    pulse_start();
    check_eq("t2_ready", {31'd0, in_ready}, 32'd1);
    check_eq("t2_done_clr", {31'd0, done}, 32'd0);
    send_byte(8'h00); send_byte(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00);
`endif
    check_done_seq("t2");
    check_eq("t2_nwr", wr_addr_q.size(), 32'd0);

    // 3: N=1025 exceeds depth.
    pulse_start();
    send_byte(8'h04); send_byte(8'h01);
    check_eq("t3_error", {31'd0, error}, 32'd1);
    check_eq("t3_ready", {31'd0, in_ready}, 32'd0);
    check_eq("t3_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t3_error_hold", {31'd0, error}, 32'd1);
    check_eq("t3_nwr", wr_addr_q.size(), 32'd0);
    pulse_start();
    check_eq("t3_restart_ready", {31'd0, in_ready}, 32'd1);
    check_eq("t3_restart_error", {31'd0, error}, 32'd0);

    // 4: two words with random valid gaps.
    send_byte(8'h00); idle($urandom_range(0, 3));
    send_byte(8'h02); idle($urandom_range(0, 3));
    send_byte(8'h18); idle($urandom_range(1, 3));
    check_eq("t4_no_early_wr", wr_addr_q.size(), 32'd0);
    send_byte(8'h04); idle($urandom_range(0, 3));
    send_byte(8'h08); idle($urandom_range(1, 3));
    check_eq("t4_one_wr", wr_addr_q.size(), 32'd1);
    send_byte(8'h01);
`ifdef LOADER_CHECKSUM_EN
    idle($urandom_range(0, 3));
    send_byte(8'h15);
`endif
    check_done_seq("t4");
    check_eq("t4_nwr", wr_addr_q.size(), 32'd2);
    check_write("t4_w0", 0, 11'd0, 16'h1804);
    check_write("t4_w1", 1, 11'd1, 16'h0801);

    // 5: reset mid-load, then reload a single word.
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h18); send_byte(8'h04);
    in_valid = 1'b0;
    check_eq("t5_we_before_rst", {31'd0, mem_we}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    check_write("t5_pre", 0, 11'd0, 16'h1804);
    rst = 1'b1;
    @(negedge clk);
    wr_addr_q.delete();
    wr_data_q.delete();
    check_eq("t5_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hAB); send_byte(8'hCD);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h66);
`endif
    check_done_seq("t5");
    check_eq("t5_nwr", wr_addr_q.size(), 32'd1);
    check_write("t5_w0", 0, 11'd0, 16'hABCD);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum match and mismatch.
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h18); send_byte(8'h04);
    send_byte(8'h1C);
    check_done_seq("t6a");
    pulse_start();
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h18); send_byte(8'h04);
    send_byte(8'h1D);
    in_valid = 1'b0;
    check_eq("t6b_error", {31'd0, error}, 32'd1);
    check_eq("t6b_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
    @(negedge clk);
    check_eq("t6b_done", {31'd0, done}, 32'd0);
    check_write("t6b_w0", 0, 11'd0, 16'h1804);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
